msx_mouse_port: RTL and testbench

Converts host mouse packets into the MSX mouse protocol on joystick port A. The MSX polls the mouse by toggling the port strobe pin and reading four successive 4-bit nibbles. This block sits between user_io (mouse_x/mouse_y/mouse_flags/mouse_strobe) and the emsx_top joystick-A input. It accumulates motion between MSX polls with saturation, so no movement is lost when host packets arrive faster than the MSX reads.

---
 rtl/msx_mouse_port.sv | 158 +++++++++++++++
 tb/tb_msx_mouse_port.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/msx_mouse_port.sv
// msx_mouse_port: turns host mouse packets into the nibble-serial MSX mouse
// protocol on joystick port A. Motion accumulates with saturation between
// MSX polls. Each strobe toggle from the MSX steps through X-high, X-low,
// Y-high and Y-low nibbles.
module msx_mouse_port #(
    parameter logic [17:0] TIMEOUT = 18'd32000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       mouse_strobe,
    input  logic [7:0] mouse_x,
    input  logic [7:0] mouse_y,
    input  logic [7:0] mouse_flags,
    input  logic       stra,
    input  logic       joy_activity,
    output logic       active,
    output logic [5:0] port_out
);

    typedef enum logic [1:0] {S_XH, S_XL, S_YH, S_YL} state_t;

    state_t      state_q, state_d;
    logic        active_q, active_d;
    logic        stra_d_q, stra_d_d;
    logic [5:0]  port_q, port_d;
    logic [7:0]  ax_q, ax_d;
    logic [7:0]  ay_q, ay_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  ty_q, ty_d;
    logic [17:0] cnt_q, cnt_d;

    logic [8:0]  dx, dy;
    logic [7:0]  ax_add, ay_add, dx_sat, dy_sat, neg_ax;
    logic        toggle;
    logic        unused_flags;

    // Clamp a 10-bit two's complement value into the signed 8-bit range
    function automatic logic [7:0] sat10(input logic [9:0] v);
        logic [7:0] r;
        if ($signed(v) > 10'sd127) begin
            r = 8'h7F;
        end else if ($signed(v) < -10'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    assign unused_flags = ^{mouse_flags[7:6], mouse_flags[3:2]};

    // Next-state logic: accumulation, nibble sequencing, timeout, hand-back
    always_comb begin
        dx     = {mouse_flags[4], mouse_x};
        dy     = {mouse_flags[5], mouse_y};
        ax_add = sat10({{2{ax_q[7]}}, ax_q} + {dx[8], dx});
        ay_add = sat10({{2{ay_q[7]}}, ay_q} + {dy[8], dy});
        dx_sat = sat10({dx[8], dx});
        dy_sat = sat10({dy[8], dy});
        // MSX treats positive X as leftward, hence the negation
        neg_ax = sat10(10'd0 - {{2{ax_q[7]}}, ax_q});
        toggle = active_q & (stra ^ stra_d_q);

        state_d  = state_q;
        active_d = active_q;
        stra_d_d = stra;
        port_d   = port_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        cnt_d    = cnt_q;

        if (cnt_q != 18'd0) begin
            cnt_d = cnt_q - 18'd1;
            if (cnt_q == 18'd1) begin
                state_d = S_XH;
            end
        end

        if (toggle) begin
            cnt_d = TIMEOUT;
            case (state_q)
                S_XH: begin
                    tx_d        = neg_ax;
                    ty_d        = ay_q;
                    ax_d        = 8'h00;
                    ay_d        = 8'h00;
                    port_d[3:0] = neg_ax[7:4];
                    state_d     = S_XL;
                end
                S_XL: begin
                    port_d[3:0] = tx_q[3:0];
                    state_d     = S_YH;
                end
                S_YH: begin
                    port_d[3:0] = ty_q[7:4];
                    state_d     = S_YL;
                end
                default: begin
                    port_d[3:0] = ty_q[3:0];
                    state_d     = S_XH;
                end
            endcase
        end

        if (mouse_strobe) begin
            active_d    = 1'b1;
            port_d[5:4] = ~mouse_flags[1:0];
            // A packet landing on the snapshot cycle starts a fresh accumulation
            if (toggle && (state_q == S_XH)) begin
                ax_d = dx_sat;
                ay_d = dy_sat;
            end else begin
                ax_d = ax_add;
                ay_d = ay_add;
            end
        end else if (joy_activity) begin
            active_d = 1'b0;
            state_d  = S_XH;
            ax_d     = 8'h00;
            ay_d     = 8'h00;
            tx_d     = 8'h00;
            ty_d     = 8'h00;
            port_d   = 6'h3F;
            cnt_d    = 18'd0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= S_XH;
            active_q <= 1'b0;
            stra_d_q <= 1'b0;
            port_q   <= 6'h3F;
            ax_q     <= 8'h00;
            ay_q     <= 8'h00;
            tx_q     <= 8'h00;
            ty_q     <= 8'h00;
            cnt_q    <= 18'd0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            stra_d_q <= stra_d_d;
            port_q   <= port_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            cnt_q    <= cnt_d;
        end
    end

    assign active   = active_q;
    assign port_out = port_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// tb_msx_mouse_port: directed stimulus with a scoreboard queue; a monitor
// process pops each expectation when it falls due and compares it against
// {active, port_out}.
module tb_msx_mouse_port;

    localparam logic [17:0] TMO = 18'd300;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       mouse_strobe;
    logic [7:0] mouse_x;
    logic [7:0] mouse_y;
    logic [7:0] mouse_flags;
    logic       stra;
    logic       joy_activity;
    logic       active;
    logic [5:0] port_out;

    typedef struct {
        string      name;
        logic [6:0] want;
        int         due;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic [6:0] got;

    msx_mouse_port #(.TIMEOUT(TMO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .mouse_strobe (mouse_strobe),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_flags  (mouse_flags),
        .stra         (stra),
        .joy_activity (joy_activity),
        .active       (active),
        .port_out     (port_out)
    );

    // Free-running clock
    always #5 clk_sys = ~clk_sys;

    // Cycle count used to schedule when each expectation falls due
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Monitor: compare every expectation whose due cycle has arrived
    always @(negedge clk_sys) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e   = sb_q.pop_front();
            got = {active, port_out};
            total++;
            if (got !== e.want) begin
                bad++;
                $display("[TB] FAIL %s: got active=%0b port_out=%h, want active=%0b port_out=%h",
                         e.name, got[6], got[5:0], e.want[6], e.want[5:0]);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic expect_out(input string name, input logic act, input logic [5:0] port,
                              input int delay);
        exp_t x;
        x.name = name;
        x.want = {act, port};
        x.due  = cyc + delay;
        sb_q.push_back(x);
    endtask

    // One host packet, then the expected port state after it lands
    task automatic send_packet(input string name, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] flags, input logic [5:0] want_port);
        @(negedge clk_sys);
        mouse_x      = x;
        mouse_y      = y;
        mouse_flags  = flags;
        mouse_strobe = 1'b1;
        @(negedge clk_sys);
        mouse_strobe = 1'b0;
        expect_out(name, 1'b1, want_port, 3);
        wait_cycles(10);
    endtask

    // One MSX strobe toggle and the expected port state afterwards
    task automatic toggle_stra(input string name, input logic act, input logic [5:0] want_port);
        @(negedge clk_sys);
        stra = ~stra;
        expect_out(name, act, want_port, 3);
        wait_cycles(20);
    endtask

    initial begin
        reset        = 1'b1;
        mouse_strobe = 1'b0;
        mouse_x      = 8'h00;
        mouse_y      = 8'h00;
        mouse_flags  = 8'h00;
        stra         = 1'b0;
        joy_activity = 1'b0;
        wait_cycles(3);
        expect_out("reset_state", 1'b0, 6'h3F, 1);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(5);

        // Basic packet: dx=+5, dy=-3, left button held
        send_packet("pkt_basic", 8'h05, 8'hFD, 8'h21, 6'h2F);
        toggle_stra("basic_xh", 1'b1, 6'h2F);
        toggle_stra("basic_xl", 1'b1, 6'h2B);
        toggle_stra("basic_yh", 1'b1, 6'h2F);
        toggle_stra("basic_yl", 1'b1, 6'h2D);

        // Positive saturation: ax pins at +127, snapshot is -127 (0x81)
        for (int i = 0; i < 4; i++) send_packet("pkt_sat_pos", 8'd100, 8'h00, 8'h00, 6'h3D);
        toggle_stra("satpos_xh", 1'b1, 6'h38);
        toggle_stra("satpos_xl", 1'b1, 6'h31);
        toggle_stra("satpos_yh", 1'b1, 6'h30);
        toggle_stra("satpos_yl", 1'b1, 6'h30);

        // Negative saturation: ax pins at -128, negation clamps to +127
        for (int i = 0; i < 2; i++) send_packet("pkt_sat_neg", 8'h80, 8'h00, 8'h10, 6'h30);
        toggle_stra("satneg_xh", 1'b1, 6'h37);
        toggle_stra("satneg_xl", 1'b1, 6'h3F);
        toggle_stra("satneg_yh", 1'b1, 6'h30);
        toggle_stra("satneg_yl", 1'b1, 6'h30);

        // Timeout mid-sequence: next toggle restarts at X-high of a new snapshot
        send_packet("pkt_tmo1", 8'h10, 8'h00, 8'h00, 6'h30);
        toggle_stra("tmo_xh", 1'b1, 6'h3F);
        toggle_stra("tmo_xl", 1'b1, 6'h30);
        wait_cycles(int'(TMO) + 5);
        send_packet("pkt_tmo2", 8'h20, 8'h00, 8'h00, 6'h30);
        toggle_stra("tmo_restart_xh", 1'b1, 6'h3E);
        toggle_stra("tmo_restart_xl", 1'b1, 6'h30);
        toggle_stra("tmo_restart_yh", 1'b1, 6'h30);
        toggle_stra("tmo_restart_yl", 1'b1, 6'h30);

        // Packet in the same cycle as the X-high toggle
        send_packet("pkt_same1", 8'h07, 8'h00, 8'h00, 6'h30);
        @(negedge clk_sys);
        stra         = ~stra;
        mouse_x      = 8'h02;
        mouse_y      = 8'h00;
        mouse_flags  = 8'h00;
        mouse_strobe = 1'b1;
        @(negedge clk_sys);
        mouse_strobe = 1'b0;
        expect_out("same_xh", 1'b1, 6'h3F, 3);
        wait_cycles(20);
        toggle_stra("same_xl", 1'b1, 6'h39);
        toggle_stra("same_yh", 1'b1, 6'h30);
        toggle_stra("same_yl", 1'b1, 6'h30);
        toggle_stra("next_xh", 1'b1, 6'h3F);
        toggle_stra("next_xl", 1'b1, 6'h3E);
        toggle_stra("next_yh", 1'b1, 6'h30);
        toggle_stra("next_yl", 1'b1, 6'h30);

        // Joystick hand-back, ignored toggle, then re-enable with both buttons
        @(negedge clk_sys);
        joy_activity = 1'b1;
        @(negedge clk_sys);
        joy_activity = 1'b0;
        expect_out("joy_release", 1'b0, 6'h3F, 1);
        wait_cycles(10);
        toggle_stra("joy_ignored", 1'b0, 6'h3F);
        send_packet("pkt_reenable", 8'h11, 8'h00, 8'h03, 6'h0F);
        toggle_stra("reen_xh", 1'b1, 6'h0E);
        toggle_stra("reen_xl", 1'b1, 6'h0F);
        toggle_stra("reen_yh", 1'b1, 6'h00);
        toggle_stra("reen_yl", 1'b1, 6'h00);

        // Reset between Y-high and Y-low, then a fresh sequence
        send_packet("pkt_rst", 8'h11, 8'h00, 8'h00, 6'h30);
        toggle_stra("rst_xh", 1'b1, 6'h3E);
        toggle_stra("rst_xl", 1'b1, 6'h3F);
        toggle_stra("rst_yh", 1'b1, 6'h30);
        @(negedge clk_sys);
        reset = 1'b1;
        expect_out("rst_mid", 1'b0, 6'h3F, 1);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(5);
        send_packet("pkt_after_rst", 8'h30, 8'h00, 8'h00, 6'h3F);
        toggle_stra("after_rst_xh", 1'b1, 6'h3D);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(negedge clk_sys);
        if (sb_q.size() > 0) begin
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb_q.size());
            total += sb_q.size();
            bad   += sb_q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
